// File: rtl/jt7759_pack_pkg.sv
// Shared command-format constants and FSM state type for the jt7759 stream packer.
package jt7759_pack_pkg;
    localparam logic [1:0] CMD_SIL  = 2'd0;
    localparam logic [1:0] CMD_PLAY = 2'd1;
    localparam logic [1:0] CMD_LONG = 2'd2;
    localparam logic [1:0] CMD_REP  = 2'd3;  // playback understands it; the packer never emits it
    localparam int         BLK_NIBS = 256;
    localparam logic [7:0] END_MARK = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE, ST_DUMMY, ST_COLLECT, ST_HDR, ST_CNT,
        ST_DATA, ST_SIL, ST_END, ST_DONE
    } state_t;

    function automatic logic [5:0] sil_units(input logic [5:0] len);
        return (len == 6'd0) ? 6'd1 : len;
    endfunction
endpackage

// File: rtl/jt7759_pack_buf.sv
// 128-byte segment buffer: write pointer doubles as the nibble-pair count.
module jt7759_pack_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       we,
    input  logic [7:0] wdata,
    input  logic       rd_adv,
    output logic [7:0] rdata,
    output logic [7:0] cnt,
    output logic       rd_last
);
    logic [7:0] mem [0:127];
    logic [6:0] rd_ptr;

    always_ff @(posedge clk)
        if (we) mem[cnt[6:0]] <= wdata;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt    <= 8'd0;
            rd_ptr <= 7'd0;
        end else begin
            if (we)     cnt    <= cnt + 8'd1;
            if (rd_adv) rd_ptr <= rd_ptr + 7'd1;
        end
    end

    assign rdata   = mem[rd_ptr];
    assign rd_last = ({1'b0, rd_ptr} == (cnt - 8'd1));
endmodule

// File: rtl/jt7759_pack.sv
// jt7759 sample-ROM writer: packs ADPCM nibbles and silences into the playback byte format.
module jt7759_pack
    import jt7759_pack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base,
    input  logic [5:0]  divby,
    input  logic [3:0]  nib_din,
    input  logic        nib_valid,
    input  logic        nib_last,
    output logic        nib_ready,
    input  logic        sil_valid,
    input  logic [5:0]  sil_len,
    output logic        sil_ready,
    input  logic        finish,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_ok,
    output logic [16:0] end_addr
);
    state_t     state;
    logic [3:0] hi_r;
    logic       half;
    logic [5:0] div_r, sil_r;
    logic       buf_we, buf_clr, buf_rd, buf_last;
    logic [7:0] buf_wdata, buf_rdata, buf_cnt;
    logic [8:0] nib_cnt;
    logic       nib_acc, sil_acc, flush, wr_ack, blk_full;

    assign nib_cnt   = {buf_cnt, 1'b0} + {8'd0, half};
    assign nib_ready = (state == ST_COLLECT) && (nib_cnt < 9'(BLK_NIBS));
    assign sil_ready = (state == ST_COLLECT) && (nib_cnt == 9'd0) && !nib_valid;
    assign nib_acc   = nib_valid & nib_ready;
    assign sil_acc   = sil_valid & sil_ready;
    // finish on an odd count pushes the pending high nibble with a zero low nibble
    assign flush     = (state == ST_COLLECT) && !nib_valid && finish && half;
    assign blk_full  = (buf_cnt == 8'(BLK_NIBS / 2));
    assign mem_we    = state inside {ST_DUMMY, ST_HDR, ST_CNT, ST_DATA, ST_SIL, ST_END};
    assign wr_ack    = mem_we & mem_ok;

    assign buf_we    = (nib_acc & (half | nib_last)) | flush;
    assign buf_wdata = (nib_acc &  half) ? {hi_r, nib_din} :
                        nib_acc          ? {nib_din, 4'h0} : {hi_r, 4'h0};
    assign buf_clr   = ((state == ST_IDLE) && start) || ((state == ST_DATA) && mem_ok && buf_last);
    assign buf_rd    = (state == ST_DATA) && mem_ok;

    always_comb begin
        mem_din = END_MARK;
        case (state)
            ST_HDR:  mem_din = {blk_full ? CMD_PLAY : CMD_LONG, div_r};
            ST_CNT:  mem_din = {buf_cnt[6:0], 1'b0} - 8'd1;
            ST_DATA: mem_din = buf_rdata;
            ST_SIL:  mem_din = {CMD_SIL, sil_r};
            default: mem_din = END_MARK;
        endcase
    end

    jt7759_pack_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .we     (buf_we),
        .wdata  (buf_wdata),
        .rd_adv (buf_rd),
        .rdata  (buf_rdata),
        .cnt    (buf_cnt),
        .rd_last(buf_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_addr <= 17'd0;
            end_addr <= 17'd0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi_r     <= 4'd0;
            half     <= 1'b0;
            div_r    <= 6'd0;
            sil_r    <= 6'd0;
        end else begin
            done <= 1'b0;
            if (wr_ack) begin
                mem_addr <= mem_addr + 17'd1;
                if (&mem_addr) ovf <= 1'b1;
            end
            case (state)
                ST_IDLE: if (start) begin
                    state    <= ST_DUMMY;
                    mem_addr <= {base, 1'b0};
                    ovf      <= 1'b0;
                    busy     <= 1'b1;
                    half     <= 1'b0;
                end
                ST_DUMMY: if (mem_ok) state <= ST_COLLECT;
                ST_COLLECT: begin
                    if (nib_acc) begin
                        if (nib_cnt == 9'd0) div_r <= divby;
                        hi_r <= nib_din;
                        half <= ~half & ~nib_last;
                        if (nib_last || (half && buf_cnt == 8'(BLK_NIBS / 2 - 1))) state <= ST_HDR;
                    end else if (sil_acc) begin
                        sil_r <= sil_units(sil_len);
                        state <= ST_SIL;
                    end else if (finish) begin
                        half  <= 1'b0;
                        state <= (nib_cnt == 9'd0) ? ST_END : ST_HDR;
                    end
                end
                ST_HDR:  if (mem_ok) state <= blk_full ? ST_DATA : ST_CNT;
                ST_CNT:  if (mem_ok) state <= ST_DATA;
                ST_DATA: if (mem_ok && buf_last) state <= ST_COLLECT;
                ST_SIL:  if (mem_ok) state <= ST_COLLECT;
                ST_END: if (mem_ok) begin
                    end_addr <= mem_addr;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jt7759_pack.sv
// Directed bench for jt7759_pack: expected bytes queued on stimulus, popped on each completed write.
module tb_jt7759_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = 16'd0;
    logic [5:0]  divby = 6'd0;
    logic [3:0]  nib_din = 4'd0;
    logic        nib_valid = 1'b0, nib_last = 1'b0;
    logic        nib_ready;
    logic        sil_valid = 1'b0;
    logic [5:0]  sil_len = 6'd0;
    logic        sil_ready;
    logic        finish = 1'b0;
    logic        busy, done, ovf, mem_we;
    logic [16:0] mem_addr, end_addr;
    logic [7:0]  mem_din;
    logic        mem_ok = 1'b1;

    jt7759_pack dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .divby(divby),
        .nib_din(nib_din), .nib_valid(nib_valid), .nib_last(nib_last), .nib_ready(nib_ready),
        .sil_valid(sil_valid), .sil_len(sil_len), .sil_ready(sil_ready),
        .finish(finish), .busy(busy), .done(done), .ovf(ovf),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ok(mem_ok),
        .end_addr(end_addr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] sb[$];
    logic [3:0]  seg_q[$];
    logic [5:0]  seg_div;
    logic [16:0] ea;
    logic        ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] d);
        sb.push_back({1'b1, ea, d});
        ea = ea + 17'd1;
    endtask

    // Expected bytes for one closed segment: pad to even, header, optional count, pairs.
    task automatic close_seg();
        int n;
        n = seg_q.size();
        if (n % 2 == 1) begin seg_q.push_back(4'h0); n++; end
        if (n == 256) push({2'b01, seg_div});
        else begin
            push({2'b10, seg_div});
            push(8'(n - 1));
        end
        for (int i = 0; i < n; i += 2) push({seg_q[i], seg_q[i+1]});
        seg_q.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_snd(input logic [15:0] b);
        ea = {b, 1'b0};
        push(8'h00);
        base = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("ovf_cleared_by_start", {31'd0, ovf}, 0);
    endtask

    task automatic send_nib(input logic [3:0] d, input logic last, input logic [5:0] dv);
        divby = dv;
        if (seg_q.size() == 0) seg_div = dv;
        nib_din = d; nib_valid = 1'b1; nib_last = last;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); ok = nib_ready;
            @(posedge clk); #1;
        end
        chk("nib_accept", {31'd0, ok}, 1);
        nib_valid = 1'b0; nib_last = 1'b0;
        seg_q.push_back(d);
        if (last || seg_q.size() == 256) close_seg();
    endtask

    task automatic send_sil(input logic [5:0] len);
        sil_len = len; sil_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); ok = sil_ready;
            @(posedge clk); #1;
        end
        chk("sil_accept", {31'd0, ok}, 1);
        sil_valid = 1'b0;
        push({2'b00, (len == 6'd0) ? 6'd1 : len});
    endtask

    task automatic end_snd();
        logic [16:0] exp_end;
        if (seg_q.size() > 0) close_seg();
        exp_end = ea;
        push(8'h00);
        finish = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk); ok = done;
            if (!ok) begin @(posedge clk); #1; end
        end
        chk("done_seen", {31'd0, ok}, 1);
        chk("end_addr", {15'd0, end_addr}, {15'd0, exp_end});
        chk("busy_low_at_done", {31'd0, busy}, 0);
        finish = 1'b0;
        tick();
        chk("done_pulse_one_cycle", {31'd0, done}, 0);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    // Write monitor: each completed write must match the head of the scoreboard.
    initial begin
        logic [25:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst && mem_we && mem_ok) begin
                exp_w = (sb.size() > 0) ? sb.pop_front() : 26'd0;
                chk("mem_write", {6'd0, 1'b1, mem_addr, mem_din}, {6'd0, exp_w});
            end
        end
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_we",    {31'd0, mem_we}, 0);
        chk("rst_busy",      {31'd0, busy}, 0);
        chk("rst_done",      {31'd0, done}, 0);
        chk("rst_ovf",       {31'd0, ovf}, 0);
        chk("rst_mem_addr",  {15'd0, mem_addr}, 0);
        chk("rst_mem_din",   {24'd0, mem_din}, 0);
        chk("rst_end_addr",  {15'd0, end_addr}, 0);
        chk("rst_nib_ready", {31'd0, nib_ready}, 0);
        chk("rst_sil_ready", {31'd0, sil_ready}, 0);
        tick();

        // 1: one full 256-nibble block
        start_snd(16'h0010);
        for (int i = 0; i < 256; i++) send_nib(4'(i), 1'b0, 6'd5);
        end_snd();
        chk("t1_end_addr", {15'd0, end_addr}, 32'hA2);

        // 2: short segment with last, plus a 10-cycle mem_ok stall on the header
        start_snd(16'h0100);
        for (int i = 1; i <= 9; i++) send_nib(4'(i), 1'b0, 6'd3);
        mem_ok = 1'b0;
        send_nib(4'hA, 1'b1, 6'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_we",   {31'd0, mem_we}, 1);
            chk("stall_addr", {15'd0, mem_addr}, 32'h201);
            chk("stall_din",  {24'd0, mem_din}, 32'h83);
            tick();
        end
        mem_ok = 1'b1;
        end_snd();

        // 3: odd count padded by nib_last
        start_snd(16'h0200);
        for (int i = 1; i <= 7; i++) send_nib(4'(i), i == 7, 6'd2);
        end_snd();

        // 4: silences, nibble priority over silence, odd flush by finish
        start_snd(16'h0300);
        send_sil(6'd5);
        send_sil(6'd0);
        divby = 6'd7; seg_div = 6'd7;
        nib_din = 4'hA; nib_valid = 1'b1; sil_valid = 1'b1; sil_len = 6'd3;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = nib_ready;
            if (!ok) begin @(posedge clk); #1; end
        end
        chk("simul_nib_ready", {31'd0, nib_ready}, 1);
        chk("simul_sil_ready", {31'd0, sil_ready}, 0);
        tick();
        nib_valid = 1'b0; sil_valid = 1'b0;
        seg_q.push_back(4'hA);
        send_nib(4'hB, 1'b0, 6'd7);
        send_nib(4'hC, 1'b0, 6'd7);
        end_snd();

        // 5: 300 continuous nibbles
        start_snd(16'h0400);
        for (int i = 0; i < 300; i++) send_nib(4'(i), 1'b0, 6'd9);
        end_snd();

        // 6a: reset in the middle of DATA
        start_snd(16'h0300);
        for (int i = 1; i <= 4; i++) send_nib(4'(i), i == 4, 6'd0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = mem_we && (mem_addr == 17'h603);
            if (!ok) begin @(posedge clk); #1; end
        end
        chk("data_reached", {31'd0, ok}, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_mem_we",    {31'd0, mem_we}, 0);
        chk("midrst_busy",      {31'd0, busy}, 0);
        chk("midrst_nib_ready", {31'd0, nib_ready}, 0);
        rst = 1'b0;
        sb.delete(); seg_q.delete();
        tick();

        // 6b: address wrap sets ovf; next start clears it
        start_snd(16'hFFFF);
        for (int i = 1; i <= 4; i++) send_nib(4'(i), i == 4, 6'd2);
        end_snd();
        chk("wrap_ovf",      {31'd0, ovf}, 1);
        chk("wrap_end_addr", {15'd0, end_addr}, 32'h3);
        start_snd(16'h0040);
        end_snd();
        chk("empty_end_addr", {15'd0, end_addr}, 32'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
